dmem_access_ctrl: RTL and testbench

Sequences and shares the single-port data memory between two requesters: the pipeline MEM stage (cpu) and a debug/program loader port (dbg).
- Issues one memory access at a time, waits the memory's fixed read latency, and returns registered read data with a one-cycle done pulse.
- Drives cpu_stall so the pipeline freezes while its access is outstanding.
- Sits between the MEM stage / loader and the DataMemory instance.

---
 rtl/dmem_ctrl_pkg.sv | 20 ++
 rtl/dmem_arb_pick.sv | 42 ++++
 rtl/dmem_access_ctrl.sv | 138 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds the FSM state encoding, the requester identity and the legal read-latency range.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// cpu/dbg priority decision with a starvation counter that forces a dbg grant
// after STARVE_MAX consecutive cpu wins while dbg is waiting.
module dmem_arb_pick
  import dmem_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   arb_en,
  input  logic   cpu_req,
  input  logic   dbg_req,
  output logic   grant,
  output owner_t owner
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = cpu_req | dbg_req;
    owner = OWN_CPU;
    if (dbg_req && (!cpu_req || starve_cnt == STARVE_LIM)) owner = OWN_DBG;
  end

  // The counter only moves on arbitration cycles; outside IDLE it is frozen.
  // NOTE: sequential state is written with non-blocking assignments only, so all
  // flops in the design update together on the edge regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!dbg_req || owner == OWN_DBG) starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares one single-port data memory between the MEM stage (cpu) and a debug loader (dbg),
// one access at a time: IDLE -> ISSUE -> [WAIT x RD_LAT for reads] -> RESP -> IDLE.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("dmem_access_ctrl: RD_LAT must lie in 1..4");
  end

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_t            state;
  owner_t            owner_q;
  logic              we_q;
  logic [2:0]        wait_cnt;
  logic              grant;
  owner_t            grant_owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  dmem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .arb_en  (state == IDLE),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .grant   (grant),
    .owner   (grant_owner)
  );

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_owner == OWN_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  // NOTE: the datapath latches and read-data registers are reset along with the
  // control state, because every one of them is a visible output that must read 0
  // the moment reset asserts, even mid-access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner_q   <= OWN_CPU;
      we_q      <= 1'b0;
      wait_cnt  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      dbg_done  <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state     <= ISSUE;
            owner_q   <= grant_owner;
            we_q      <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_re    <= ~sel_we;
            mem_we    <= sel_we;
          end
        end
        ISSUE: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          if (we_q) begin
            state    <= RESP;
            cpu_done <= (owner_q == OWN_CPU);
            dbg_done <= (owner_q == OWN_DBG);
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          // Last WAIT cycle is when the memory's read data is valid.
          if (wait_cnt == '0) begin
            state    <= RESP;
            cpu_done <= (owner_q == OWN_CPU);
            dbg_done <= (owner_q == OWN_DBG);
            if (owner_q == OWN_CPU) cpu_rdata <= mem_rdata;
            else                    dbg_rdata <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          cpu_done  <= 1'b0;
          dbg_done  <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a transaction-level model predicts every strobe,
// address window and done pulse; a negedge monitor compares them against the DUT.
module tb_dmem_access_ctrl;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 4;
  localparam int BIG        = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done, cpu_stall;
  logic              dbg_req = 1'b0, dbg_we = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wdata = '0;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_done;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  dmem_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory stand-in: data for a strobe at cycle t is valid only during cycle t+RD_LAT.
  bit [31:0] mem [256];
  bit        pipe_v [RD_LAT];
  bit [31:0] pipe_d [RD_LAT];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    pipe_v[0] <= mem_re;
    pipe_d[0] <= mem[mem_addr[9:2]];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBADC_0FFE;

  int checks = 0, errors = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct { int cyc; bit re; bit we; } strobe_t;
  typedef struct { int cyc; int owner; bit we; logic [31:0] rdata; } resp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } plan_t;
  typedef struct {
    bit active; bit granted; bit dropped; bit we;
    logic [31:0] addr; logic [31:0] wdata; int done_cyc;
  } rq_t;

  strobe_t     strobe_q[$];
  resp_t       resp_q[$];
  logic [31:0] exp_addr [int];
  logic [31:0] exp_wdata [int];
  logic [31:0] exp_cpu_rdata = '0, exp_dbg_rdata = '0;
  int          obs_log[$];
  bit [31:0]   shadow [256];
  plan_t       plan_cpu[$], plan_dbg[$];
  rq_t         rq [2];
  int          free_at = BIG, starve = 0;
  bit          in_reset = 1'b1;
  int          p_new [2] = '{0, 0};
  int          p_drop = 0, force_we = -1;

  task automatic flush_model();
    strobe_q.delete(); resp_q.delete();
    exp_addr.delete(); exp_wdata.delete();
    exp_cpu_rdata = '0; exp_dbg_rdata = '0;
    starve = 0; free_at = BIG;
  endtask

  task automatic apply_pins();
    cpu_req = rq[0].active && !rq[0].dropped; cpu_we = rq[0].we;
    cpu_addr = rq[0].addr; cpu_wdata = rq[0].wdata;
    dbg_req = rq[1].active && !rq[1].dropped; dbg_we = rq[1].we;
    dbg_addr = rq[1].addr; dbg_wdata = rq[1].wdata;
  endtask

  // One access occupies the memory for 2 (write) or 2+RD_LAT (read) cycles after
  // the grant cycle, then one IDLE cycle must pass before the next grant.
  task automatic grant_to(int w, int c);
    int lat;
    logic [31:0] rd;
    lat = rq[w].we ? 2 : 2 + RD_LAT;
    rq[w].granted = 1; rq[w].done_cyc = c + lat;
    free_at = c + lat + 1;
    strobe_q.push_back('{c + 1, !rq[w].we, rq[w].we});
    for (int k = c + 1; k <= c + lat; k++) begin
      exp_addr[k] = rq[w].addr; exp_wdata[k] = rq[w].wdata;
    end
    rd = '0;
    if (rq[w].we) shadow[rq[w].addr[9:2]] = rq[w].wdata;
    else          rd = shadow[rq[w].addr[9:2]];
    resp_q.push_back('{c + lat, w, rq[w].we, rd});
  endtask

  task automatic arbitrate(int c);
    int w;
    w = -1;
    if (cpu_req && dbg_req) w = (starve == STARVE_MAX) ? 1 : 0;
    else if (cpu_req)       w = 0;
    else if (dbg_req)       w = 1;
    if (w == 0 && dbg_req) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    else if (w == 1 || !dbg_req) starve = 0;
    if (w >= 0) grant_to(w, c);
  endtask

  task automatic drive_and_model();
    int c;
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      if (rq[i].active && rq[i].granted && c > rq[i].done_cyc) rq[i].active = 0;
      if (!rq[i].active) begin
        plan_t p;
        bit got;
        got = 0;
        if (i == 0 && plan_cpu.size() > 0) begin p = plan_cpu.pop_front(); got = 1; end
        else if (i == 1 && plan_dbg.size() > 0) begin p = plan_dbg.pop_front(); got = 1; end
        else if (!in_reset && $urandom_range(99) < p_new[i]) begin
          p.we    = (force_we < 0) ? 1'($urandom_range(1)) : (force_we != 0);
          p.addr  = 32'($urandom_range(15)) << 2;
          p.wdata = $urandom;
          got = 1;
        end
        if (got) rq[i] = '{1, 0, 0, p.we, p.addr, p.wdata, 0};
      end else if (rq[i].granted && !rq[i].dropped && $urandom_range(99) < p_drop) begin
        rq[i].dropped = 1;
      end
    end
    apply_pins();
    if (!in_reset && c >= free_at) arbitrate(c);
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive_and_model();
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_reset = 0; free_at = cyc;
    drive_and_model();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin step(); n++; end
    while (n < 200 && !(cyc >= free_at && !rq[0].active && !rq[1].active &&
                        plan_cpu.size() == 0 && plan_dbg.size() == 0));
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout at cycle %0d: still busy after %0d cycles", cyc, n);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    strobe_t s;
    resp_t   r;
    bit      e_re, e_we, e_cd, e_dd;
    e_re = 0; e_we = 0; e_cd = 0; e_dd = 0;
    while (strobe_q.size() > 0 && strobe_q[0].cyc < cyc) begin
      s = strobe_q.pop_front();
      check("strobe_missed", cyc, s.cyc);
    end
    while (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
      r = resp_q.pop_front();
      check("done_missed", cyc, r.cyc);
    end
    if (strobe_q.size() > 0 && strobe_q[0].cyc == cyc) begin
      s = strobe_q.pop_front(); e_re = s.re; e_we = s.we;
    end
    if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
      r = resp_q.pop_front();
      if (r.owner == 0) begin e_cd = 1; if (!r.we) exp_cpu_rdata = r.rdata; end
      else              begin e_dd = 1; if (!r.we) exp_dbg_rdata = r.rdata; end
    end
    check("mem_re", 32'(mem_re), 32'(e_re));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", mem_addr, exp_addr.exists(cyc) ? exp_addr[cyc] : 32'h0);
    check("mem_wdata", mem_wdata, exp_wdata.exists(cyc) ? exp_wdata[cyc] : 32'h0);
    check("cpu_done", 32'(cpu_done), 32'(e_cd));
    check("dbg_done", 32'(dbg_done), 32'(e_dd));
    check("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    check("dbg_rdata", dbg_rdata, exp_dbg_rdata);
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cd));
    if (cpu_done) obs_log.push_back(0);
    if (dbg_done) obs_log.push_back(1);
  end

  // ---------------- stimulus ----------------
  int exp_order [6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    int n, g;
    for (int i = 0; i < 2; i++) rq[i] = '{0, 0, 0, 0, '0, '0, 0};
    #1 reset = 1'b0;
    repeat (3) step();
    release_reset();

    // dbg writes (incl. 0x20 = 0x12345678) with cpu idle, then a cpu read of 0x10
    plan_dbg.push_back('{1, 32'h20, 32'h1234_5678});
    plan_dbg.push_back('{1, 32'h10, 32'hDEAD_BEEF});
    plan_dbg.push_back('{1, 32'h40, 32'hCAFE_F00D});
    wait_idle();
    plan_cpu.push_back('{0, 32'h10, 32'h0});
    wait_idle();

    // cpu_req held through RESP into a second read
    plan_cpu.push_back('{0, 32'h40, 32'h1111_1111});
    plan_cpu.push_back('{0, 32'h10, 32'h2222_2222});
    wait_idle();

    // both requesters continuously writing: starvation limit forces dbg in
    obs_log.delete();
    p_new = '{100, 100}; force_we = 1;
    n = 0;
    while (obs_log.size() < 6 && n < 300) begin step(); n++; end
    p_new = '{0, 0}; force_we = -1;
    if (obs_log.size() < 6) begin
      checks++; errors++;
      $display("FAIL starve_timeout: saw %0d of 6 completions", obs_log.size());
    end else begin
      for (int k = 0; k < 6; k++) check($sformatf("grant_order_%0d", k), obs_log[k], exp_order[k]);
    end
    wait_idle();

    // reset asserted two cycles after a dbg read grant; cpu read follows release
    plan_dbg.push_back('{0, 32'h20, 32'h0});
    n = 0;
    while (!(rq[1].active && rq[1].granted) && n < 50) begin step(); n++; end
    g = rq[1].done_cyc - (2 + RD_LAT);
    while (cyc < g + 1) step();
    @(posedge clk); #1;
    reset = 1'b0; in_reset = 1;
    flush_model();
    rq[0].active = 0; rq[1].active = 0;
    apply_pins();
    #1;
    check("rst_mem_re", 32'(mem_re), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_done", 32'(cpu_done), 32'h0);
    check("rst_dbg_done", 32'(dbg_done), 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    plan_cpu.push_back('{0, 32'h10, 32'h0});
    repeat (3) step();
    release_reset();
    wait_idle();

    // randomized traffic with occasional request drops after grant
    p_new = '{60, 35}; p_drop = 10;
    repeat (1500) step();
    p_new = '{0, 0}; p_drop = 0;
    wait_idle();
    repeat (3) step();
    check("resp_left", resp_q.size(), 32'h0);
    check("strobe_left", strobe_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
